// File: rtl/axi_stream_pkg.sv
// Shared types and constants for the 8-bit stream capture register.
// Reset values are collected here so the top and the counter agree on them.
package axi_stream_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } axis_beat_t;

    localparam axis_beat_t RST_BEAT  = '0;
    localparam logic       RST_VALID = 1'b0;
    localparam logic       RST_LAST  = 1'b0;

endpackage

// File: rtl/axi_stream_reg8_if.sv
// Producer-side stream handshake bundle for axi_stream_reg8.
// The producer drives it through the master modport, the capture register reads it through slave.
interface axi_stream_reg8_if #(
    parameter int DATA_W = axi_stream_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] in_data;
    logic              T_valid_in;
    logic              T_ready;
    logic              Tlast;

    modport master (output in_data, T_valid_in, T_ready, Tlast);
    modport slave  (input  in_data, T_valid_in, T_ready, Tlast);
endinterface

// File: rtl/axis_beat_counter.sv
// Beat-in-packet and completed-packet counters, both free-running modulo 2^CNT_W.
module axis_beat_counter
    import axi_stream_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc,
    input  logic             last,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] pkt_count
);

    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] pkt_q,  pkt_d;

    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (acc) begin
            if (last) begin
                beat_d = '0;
                pkt_d  = pkt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            pkt_q  <= '0;
        end else begin
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
        end
    end

    assign beat_count = beat_q;
    assign pkt_count  = pkt_q;

endmodule

// File: rtl/axi_stream_reg8.sv
// Single-stage stream capture register: holds the last accepted beat and its last flag,
// pulses out_valid for one cycle per accepted beat, and tracks beat/packet counts.
module axi_stream_reg8
    import axi_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              T_valid_in,
    input  logic              T_ready,
    input  logic              Tlast,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  pkt_count
);

    logic              acc;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    assign acc = T_valid_in & T_ready;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = 1'b0;
        if (acc) begin
            data_d  = in_data;
            last_d  = Tlast;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= RST_VALID;
            last_q  <= RST_LAST;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

    axis_beat_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .acc        (acc),
        .last       (Tlast),
        .beat_count (beat_count),
        .pkt_count  (pkt_count)
    );

endmodule

// File: tb/tb_axi_stream_reg8.sv
// Bench for axi_stream_reg8: directed scenarios plus random traffic against a
// model that tracks the last accepted beat and counts beats since the last packet end.
module tb_axi_stream_reg8;
    import axi_stream_pkg::*;

    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_stream_reg8_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] pkt_count;

    axi_stream_reg8 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (bus.in_data),
        .T_valid_in (bus.T_valid_in),
        .T_ready    (bus.T_ready),
        .Tlast      (bus.Tlast),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .beat_count (beat_count),
        .pkt_count  (pkt_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference: the most recent accepted beat, whether the last edge accepted,
    // beats seen since the previous packet end, and packets ended since reset.
    axis_beat_t m_hold;
    bit         m_valid;
    int         m_beats;
    int         m_pkts;

    logic [25:0] act;
    assign act = {out_data, out_valid, out_last, beat_count, pkt_count};

    function automatic logic [25:0] exp_vec();
        return {m_hold.data, m_valid, m_hold.last, 8'(m_beats), 8'(m_pkts)};
    endfunction

    task automatic model_reset();
        m_hold  = RST_BEAT;
        m_valid = 1'b0;
        m_beats = 0;
        m_pkts  = 0;
    endtask

    // Drive one cycle from a falling edge, let the model see the rising edge, return at the next falling edge.
    task automatic tick(input bit v, input bit r, input logic [DW-1:0] d, input bit l);
        bus.T_valid_in = v;
        bus.T_ready    = r;
        bus.in_data    = d;
        bus.Tlast      = l;
        @(posedge clk);
        if (reset) begin
            if (v && r) begin
                m_hold.data = d;
                m_hold.last = l;
                m_valid     = 1'b1;
                if (l) begin
                    m_beats = 0;
                    m_pkts  = (m_pkts + 1) % 256;
                end else begin
                    m_beats = (m_beats + 1) % 256;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 8'h12, 1'b0);
            tests++;
            if (act !== 26'h0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h expected %h (data,valid,last,beat,pkt)", i, act, 26'h0);
            end
        end
    endtask

    task automatic test_capture();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 8'h12, 1'b0);
            tests++;
            if (act !== exp_vec()) begin
                fails++;
                $display("FAIL capture[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
        tests++;
        if (beat_count !== 8'd4) begin
            fails++;
            $display("FAIL capture_beats: got %0d expected 4", beat_count);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b1, 8'h22, 1'b0);
        tests++;
        if (out_data !== 8'h22) begin
            fails++;
            $display("FAIL pre_reset_data: got %h expected 22", out_data);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if (act !== 26'h0) begin
            fails++;
            $display("FAIL async_reset: got %h expected %h before next edge", act, 26'h0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 8'h99, 1'b1);
            tests++;
            if (act !== 26'h0) begin
                fails++;
                $display("FAIL reset_held[%0d]: got %h expected %h", i, act, 26'h0);
            end
        end
        reset = 1'b1;
        tick(1'b1, 1'b1, 8'h44, 1'b0);
        tests++;
        if (act !== exp_vec() || beat_count !== 8'd1) begin
            fails++;
            $display("FAIL first_after_reset: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_no_accept();
        logic [DW-1:0] dat [3];
        bit            vv  [3];
        bit            rr  [3];
        dat = '{8'h33, 8'h55, 8'h66};
        vv  = '{1'b0, 1'b0, 1'b1};
        rr  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick(vv[i], rr[i], dat[i], 1'b1);
            tests++;
            if (act !== exp_vec() || out_data !== 8'h44 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL no_accept[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_last();
        logic [DW-1:0] dat [4];
        bit            lst [4];
        dat = '{8'h77, 8'h88, 8'hAA, 8'hBB};
        lst = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, dat[i], lst[i]);
            tests++;
            if (act !== exp_vec()) begin
                fails++;
                $display("FAIL last_seq[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
        tests++;
        if (pkt_count !== 8'd1 || beat_count !== 8'd1 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL last_counts: got pkt=%0d beat=%0d last=%b expected pkt=1 beat=1 last=0",
                     pkt_count, beat_count, out_last);
        end
    endtask

    task automatic test_coincident_reset();
        bus.T_valid_in = 1'b1;
        bus.T_ready    = 1'b1;
        bus.in_data    = 8'hC3;
        bus.Tlast      = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if (act !== 26'h0) begin
            fails++;
            $display("FAIL coincident_reset: got %h expected %h", act, 26'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 1'b1, 8'h5A, 1'b0);
        tests++;
        if (act !== exp_vec()) begin
            fails++;
            $display("FAIL after_coincident: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] beat0;
        logic [CW-1:0] pkt0;
        beat0 = beat_count;
        pkt0  = pkt_count;
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 1'b1, 8'($urandom), 1'b0);
            tests++;
            if (act !== exp_vec()) begin
                fails++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
        tests++;
        if (beat_count !== beat0 || pkt_count !== pkt0) begin
            fails++;
            $display("FAIL wrap_end: got beat=%0d pkt=%0d expected beat=%0d pkt=%0d",
                     beat_count, pkt_count, beat0, pkt0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 8'($urandom), 1'($urandom_range(0, 5) == 0));
            tests++;
            if (act !== exp_vec()) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        bus.T_valid_in = 1'b0;
        bus.T_ready    = 1'b0;
        bus.in_data    = '0;
        bus.Tlast      = 1'b0;
        test_reset();
        test_capture();
        test_async_reset();
        test_no_accept();
        test_last();
        test_coincident_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
